// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the OV7670-style stream transmitter.
package cam_pkg;
  typedef logic [15:0] rgb565_t;
  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP} tx_state_e;
  typedef enum logic [1:0] {MODE_MEM, MODE_BARS, MODE_RAMP, MODE_RSVD} tx_mode_e;
  localparam logic [0:7][15:0] BAR_COLOR = {
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };
endpackage

// File: rtl/ov7670_stream_tx_if.sv
// ov7670_stream_tx_if: control, pixel-memory and camera-side signals of the transmitter.
interface ov7670_stream_tx_if #(parameter int ADDR_WIDTH = 15);
  logic                  en;
  logic [1:0]            mode;
  logic                  pix_rd;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic [15:0]           pix_data;
  logic                  cam_pclk;
  logic                  cam_vsync;
  logic                  cam_href;
  logic [7:0]            cam_data;
  logic                  busy;
  logic                  frame_done;
  modport master (
    input  en, mode, pix_data,
    output pix_rd, pix_addr, cam_pclk, cam_vsync, cam_href, cam_data, busy, frame_done
  );
  modport slave (
    output en, mode, pix_data,
    input  pix_rd, pix_addr, cam_pclk, cam_vsync, cam_href, cam_data, busy, frame_done
  );
endinterface

// File: rtl/ov7670_test_pattern.sv
// ov7670_test_pattern: colour-bar / address-ramp pixel source, stepped once per pixel.
module ov7670_test_pattern
  import cam_pkg::*;
#(
  parameter int IMG_WIDTH  = 160,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  adv,
  input  logic                  ramp,
  input  logic [ADDR_WIDTH-1:0] addr,
  output rgb565_t               pix
);
  localparam int BW = IMG_WIDTH / 8;
  localparam int CW = $clog2(IMG_WIDTH + 1);
  // Lines narrower than 8 px have no full bars, so every column is remainder.
  localparam logic [2:0] BAR0 = (BW == 0) ? 3'd7 : 3'd0;
  logic [2:0]    bar_q, bar_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bar_end;
  always_comb begin
    bar_end = cnt_q == CW'(BW - 1);
    bar_d   = adv ? ((bar_q == 3'd7 || !bar_end) ? bar_q : bar_q + 3'd1) : clr ? BAR0 : bar_q;
    cnt_d   = adv ? ((bar_q == 3'd7 || bar_end) ? '0 : cnt_q + 1'b1) : clr ? '0 : cnt_q;
    pix     = ramp ? 16'(addr) : BAR_COLOR[bar_q];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_q <= BAR0;
      cnt_q <= '0;
    end else begin
      bar_q <= bar_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ov7670_stream_tx.sv
// ov7670_stream_tx: sensor-side OV7670 emulator producing pclk/vsync/href/data, RGB565 high byte first.
module ov7670_stream_tx
  import cam_pkg::*;
#(
  parameter int IMG_WIDTH    = 160,
  parameter int IMG_HEIGHT   = 120,
  parameter int ADDR_WIDTH   = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter int HBLANK_BYTES = 144,
  parameter int VSYNC_LINES  = 3,
  parameter int VBP_LINES    = 17,
  parameter int VFP_LINES    = 10
) (
  input logic                clk,
  input logic                reset,
  ov7670_stream_tx_if.master bus
);
  localparam int ACT_SLOTS  = 2 * IMG_WIDTH;
  localparam int LINE_SLOTS = ACT_SLOTS + HBLANK_BYTES;
  localparam int SW         = $clog2(LINE_SLOTS);
  localparam int NPIX       = IMG_WIDTH * IMG_HEIGHT;
  tx_state_e             state_q, state_d;
  tx_mode_e              mode_q, mode_d;
  logic                  ph_q, ph_d, vsync_q, vsync_d, href_q, href_d;
  logic                  rd_q, rd_d, done_q, done_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [15:0]           line_q, line_d;
  logic [7:0]            data_q, data_d, lo_q, lo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  tick, line_end, last_line, adv;
  rgb565_t               pat, src;
  ov7670_test_pattern #(.IMG_WIDTH(IMG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != ACTIVE),
    .adv   (adv),
    .ramp  (mode_q == MODE_RAMP),
    .addr  (addr_q),
    .pix   (pat)
  );
  // tick marks the ph 1->0 launch edge: every state and output change happens there.
  always_comb begin
    tick      = state_q != IDLE && ph_q;
    line_end  = slot_q == SW'(LINE_SLOTS - 1);
    last_line = line_q == 16'((state_q == VSYNC) ? VSYNC_LINES - 1 :
                              (state_q == VBP)   ? VBP_LINES - 1   :
                              (state_q == VFP)   ? VFP_LINES - 1   : IMG_HEIGHT - 1);
    ph_d      = state_q != IDLE && !ph_q;
    state_d   = state_q;
    mode_d    = mode_q;
    slot_d    = slot_q;
    line_d    = line_q;
    vsync_d   = vsync_q;
    href_d    = href_q;
    addr_d    = addr_q;
    done_d    = state_q == VFP && !ph_q && line_end && last_line;
    if (state_q == IDLE) begin
      if (bus.en) begin
        state_d = VSYNC;
        vsync_d = 1'b1;
        mode_d  = tx_mode_e'(bus.mode);
        slot_d  = '0;
        line_d  = '0;
        addr_d  = '0;
      end
    end else if (tick) begin
      slot_d = line_end ? '0 : slot_q + 1'b1;
      if (line_end) line_d = last_line ? '0 : line_q + 16'd1;
      case (state_q)
        VSYNC:  if (line_end && last_line) begin
                  state_d = VBP;
                  vsync_d = 1'b0;
                end
        VBP:    if (line_end && last_line) begin
                  state_d = ACTIVE;
                  href_d  = 1'b1;
                end
        ACTIVE: if (slot_q == SW'(ACT_SLOTS - 1)) begin
                  state_d = HBLANK;
                  href_d  = 1'b0;
                end
        HBLANK: if (line_end) begin
                  state_d = last_line ? VFP : ACTIVE;
                  href_d  = !last_line;
                end
        VFP:    if (line_end && last_line) begin
                  state_d = bus.en ? VSYNC : IDLE;
                  vsync_d = bus.en;
                  mode_d  = bus.en ? tx_mode_e'(bus.mode) : mode_q;
                  addr_d  = bus.en ? '0 : addr_q;
                end
        default: ;
      endcase
    end
    src    = (mode_q == MODE_MEM) ? bus.pix_data : pat;
    adv    = tick && state_d == ACTIVE && !slot_d[0];
    data_d = !tick ? data_q : adv ? src[15:8] : (state_d == ACTIVE) ? lo_q : 8'h00;
    lo_d   = adv ? src[7:0] : lo_q;
    if (adv) addr_d = (addr_q == ADDR_WIDTH'(NPIX - 1)) ? addr_q : addr_q + 1'b1;
    // Read one slot ahead of each high-byte slot so pix_data lands in that slot's ph=1 cycle.
    rd_d   = tick && mode_q == MODE_MEM &&
             ((state_d == ACTIVE && slot_d[0] && slot_d != SW'(ACT_SLOTS - 1)) ||
              (slot_d == SW'(LINE_SLOTS - 1) &&
               ((state_d == HBLANK && !last_line) || (state_d == VBP && last_line))));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_MEM;
      ph_q    <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      slot_q  <= '0;
      line_q  <= '0;
      data_q  <= '0;
      lo_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ph_q    <= ph_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      slot_q  <= slot_d;
      line_q  <= line_d;
      data_q  <= data_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
    end
  end
  assign bus.cam_pclk   = ph_q;
  assign bus.cam_vsync  = vsync_q;
  assign bus.cam_href   = href_q;
  assign bus.cam_data   = data_q;
  assign bus.pix_rd     = rd_q;
  assign bus.pix_addr   = addr_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_ov7670_stream_tx.sv
// tb_ov7670_stream_tx: frame-level checks of the transmitter against a byte-slot reference model.
module tb_ov7670_stream_tx;
  localparam int HB = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  ov7670_stream_tx_if #(.ADDR_WIDTH(3)) b0 ();
  ov7670_stream_tx_if #(.ADDR_WIDTH(5)) b1 ();
  ov7670_stream_tx #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .ADDR_WIDTH(3), .HBLANK_BYTES(HB),
    .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  ov7670_stream_tx #(.IMG_WIDTH(16), .IMG_HEIGHT(2), .ADDR_WIDTH(5), .HBLANK_BYTES(HB),
    .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  logic [15:0] mem [32];
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  always @(posedge clk) begin
    if (b0.pix_rd) b0.pix_data <= mem[int'(b0.pix_addr)];
    if (b1.pix_rd) b1.pix_data <= mem[int'(b1.pix_addr)];
  end
  // Monitor: one record per rising cam_pclk, plus read, done and vsync bookkeeping.
  logic sel = 1'b0;
  logic m_pclk, m_vs, m_href, m_rd, m_done;
  logic [7:0] m_data;
  int m_addr;
  always_comb begin
    m_pclk = sel ? b1.cam_pclk : b0.cam_pclk;
    m_vs   = sel ? b1.cam_vsync : b0.cam_vsync;
    m_href = sel ? b1.cam_href : b0.cam_href;
    m_data = sel ? b1.cam_data : b0.cam_data;
    m_rd   = sel ? b1.pix_rd : b0.pix_rd;
    m_done = sel ? b1.frame_done : b0.frame_done;
    m_addr = sel ? int'(b1.pix_addr) : int'(b0.pix_addr);
  end
  logic [9:0] got_q[$], exp_q[$];
  int rd_q[$], done_q[$];
  int cyc = 0, vs_first = 0, vs_cnt = 0;
  logic pclk_prev = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (m_pclk && !pclk_prev) got_q.push_back({m_vs, m_href, m_data});
    pclk_prev = m_pclk;
    if (m_rd) rd_q.push_back(m_addr);
    if (m_done) done_q.push_back(cyc);
    if (m_vs) begin
      if (vs_cnt == 0) vs_first = cyc;
      vs_cnt++;
    end
  end
  function automatic logic [15:0] pix_of(int w, int n, int md);
    int bw, b;
    if (md == 0) return mem[n];
    if (md == 2) return 16'(n);
    bw = w / 8;
    b = (bw == 0) ? 7 : (n % w) / bw;
    return bars[b > 7 ? 7 : b];
  endfunction
  // Reference frame: 1 vsync line, 1 back-porch line, h active lines, 1 front-porch line.
  function automatic void add_frame(int w, int h, int md);
    logic act;
    logic [15:0] p;
    logic [7:0] d;
    for (int l = 0; l < h + 3; l++)
      for (int s = 0; s < 2 * w + HB; s++) begin
        act = l >= 2 && l < h + 2 && s < 2 * w;
        p = act ? pix_of(w, (l - 2) * w + s / 2, md) : 16'h0;
        d = !act ? 8'h00 : (s % 2 == 0) ? p[15:8] : p[7:0];
        exp_q.push_back({l == 0, act, d});
      end
  endfunction
  function automatic int diffs();
    int n = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction
  function automatic int href_slots();
    int n = 0;
    foreach (got_q[i]) if (got_q[i][8]) n++;
    return n;
  endfunction
  function automatic int bad_addrs();
    int n = 0;
    foreach (rd_q[i]) if (rd_q[i] != i) n++;
    return n;
  endfunction
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    rd_q.delete();
    done_q.delete();
    vs_cnt = 0;
    vs_first = 0;
  endtask
  task automatic wait_done(int n, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step(1);
      ok = done_q.size() >= n;
    end
  endtask
  task automatic run_single0(int md, output bit ok);
    clear_mon();
    sel = 1'b0;
    b0.mode = 2'(md);
    b0.en = 1'b1;
    step(2);
    b0.en = 1'b0;
    wait_done(1, 300, ok);
    step(4);
  endtask
  task automatic test_reset();
    logic [16:0] o0;
    reset = 1'b1;
    step(2);
    o0 = {b0.cam_pclk, b0.cam_vsync, b0.cam_href, b0.cam_data, b0.pix_rd, b0.pix_addr, b0.busy, b0.frame_done};
    checks++;
    if (o0 !== 17'h0) begin failures++; $display("FAIL reset_outs got=%h exp=0", o0); end
    reset = 1'b0;
    step(5);
    checks++;
    if ({b0.busy, b0.cam_pclk, b1.busy, b1.cam_pclk} !== 4'b0) begin
      failures++; $display("FAIL idle_without_en got=%b exp=0000", {b0.busy, b0.cam_pclk, b1.busy, b1.cam_pclk});
    end
  endtask
  task automatic test_mem_frame();
    bit ok;
    int dt;
    for (int i = 0; i < 32; i++) mem[i] = 16'hA500 + 16'(i);
    run_single0(0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL mem_done_timeout got=0 exp=1"); end
    add_frame(4, 2, 0);
    checks++;
    if (diffs() != 0) begin failures++; $display("FAIL mem_stream bad_slots=%0d exp=0", diffs()); end
    checks++;
    if (rd_q.size() != 8) begin failures++; $display("FAIL mem_rd_count got=%0d exp=8", rd_q.size()); end
    checks++;
    if (bad_addrs() != 0) begin failures++; $display("FAIL mem_rd_addr bad=%0d exp=0", bad_addrs()); end
    dt = (done_q.size() > 0) ? done_q[0] - vs_first + 1 : -1;
    checks++;
    if (dt != 120) begin failures++; $display("FAIL frame_done_clk got=%0d exp=120", dt); end
    checks++;
    if (vs_cnt != 24) begin failures++; $display("FAIL vsync_clks got=%0d exp=24", vs_cnt); end
    checks++;
    if (href_slots() != 16) begin failures++; $display("FAIL href_slots got=%0d exp=16", href_slots()); end
    checks++;
    if ({b0.busy, b0.cam_pclk} !== 2'b00) begin failures++; $display("FAIL idle_after got=%b exp=00", {b0.busy, b0.cam_pclk}); end
  endtask
  task automatic test_random_mem();
    bit ok;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      run_single0(0, ok);
      add_frame(4, 2, 0);
      checks++;
      if (!ok || diffs() != 0) begin failures++; $display("FAIL rand_stream_%0d bad_slots=%0d done=%0d exp=0", r, diffs(), ok); end
    end
  endtask
  task automatic test_ramp();
    bit ok;
    run_single0(2, ok);
    add_frame(4, 2, 2);
    checks++;
    if (!ok || diffs() != 0) begin failures++; $display("FAIL ramp_stream bad_slots=%0d done=%0d exp=0", diffs(), ok); end
    checks++;
    if (rd_q.size() != 0) begin failures++; $display("FAIL ramp_rd_count got=%0d exp=0", rd_q.size()); end
  endtask
  task automatic test_bars();
    bit ok;
    int md;
    for (int k = 0; k < 2; k++) begin
      md = (k == 0) ? 1 : 3;
      clear_mon();
      sel = 1'b1;
      b1.mode = 2'(md);
      b1.en = 1'b1;
      step(2);
      b1.en = 1'b0;
      wait_done(1, 600, ok);
      step(4);
      add_frame(16, 2, 1);
      checks++;
      if (!ok || diffs() != 0) begin failures++; $display("FAIL bars_stream_m%0d bad_slots=%0d done=%0d exp=0", md, diffs(), ok); end
      checks++;
      if (rd_q.size() != 0) begin failures++; $display("FAIL bars_rd_m%0d got=%0d exp=0", md, rd_q.size()); end
      checks++;
      if (vs_cnt != 72) begin failures++; $display("FAIL bars_vsync_m%0d got=%0d exp=72", md, vs_cnt); end
    end
    sel = 1'b0;
  endtask
  task automatic test_en_drop();
    bit ok;
    int rises = 0;
    logic prev;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    clear_mon();
    b0.mode = 2'd0;
    b0.en = 1'b1;
    for (int i = 0; i < 300 && rises < 2; i++) begin
      prev = b0.cam_href;
      step(1);
      if (!prev && b0.cam_href) rises++;
    end
    b0.en = 1'b0;
    checks++;
    if (rises != 2) begin failures++; $display("FAIL en_drop_href_wait got=%0d exp=2", rises); end
    wait_done(1, 300, ok);
    step(20);
    add_frame(4, 2, 0);
    checks++;
    if (!ok || diffs() != 0) begin failures++; $display("FAIL en_drop_stream bad_slots=%0d done=%0d exp=0", diffs(), ok); end
    checks++;
    if (rd_q.size() != 8 || done_q.size() != 1) begin
      failures++; $display("FAIL en_drop_counts rd=%0d done=%0d exp=8,1", rd_q.size(), done_q.size());
    end
    checks++;
    if ({b0.busy, b0.cam_pclk} !== 2'b00) begin failures++; $display("FAIL en_drop_idle got=%b exp=00", {b0.busy, b0.cam_pclk}); end
  endtask
  task automatic test_back_to_back();
    bit ok1, ok2;
    int gap;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    clear_mon();
    b0.mode = 2'd0;
    b0.en = 1'b1;
    step(10);
    b0.mode = 2'd2;
    wait_done(1, 300, ok1);
    b0.en = 1'b0;
    wait_done(2, 300, ok2);
    step(4);
    add_frame(4, 2, 0);
    add_frame(4, 2, 2);
    checks++;
    if (!ok1 || !ok2 || diffs() != 0) begin failures++; $display("FAIL b2b_stream bad_slots=%0d done=%0d%0d exp=0", diffs(), ok1, ok2); end
    gap = (done_q.size() > 1) ? done_q[1] - done_q[0] : -1;
    checks++;
    if (gap != 120) begin failures++; $display("FAIL b2b_done_gap got=%0d exp=120", gap); end
    checks++;
    if (vs_cnt != 48 || rd_q.size() != 8) begin failures++; $display("FAIL b2b_counts vsync=%0d rd=%0d exp=48,8", vs_cnt, rd_q.size()); end
  endtask
  task automatic test_reset_mid_active();
    bit ok, seen = 1'b0;
    logic [16:0] o0;
    int dt;
    clear_mon();
    b0.mode = 2'd0;
    b0.en = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      step(1);
      seen = b0.cam_href;
    end
    #2 reset = 1'b1;
    #1 o0 = {b0.cam_pclk, b0.cam_vsync, b0.cam_href, b0.cam_data, b0.pix_rd, b0.pix_addr, b0.busy, b0.frame_done};
    checks++;
    if (!seen || o0 !== 17'h0) begin failures++; $display("FAIL reset_mid_active got=%h seen=%0d exp=0", o0, seen); end
    step(2);
    clear_mon();
    reset = 1'b0;
    step(2);
    b0.en = 1'b0;
    wait_done(1, 300, ok);
    step(4);
    add_frame(4, 2, 0);
    checks++;
    if (!ok || diffs() != 0) begin failures++; $display("FAIL restart_stream bad_slots=%0d done=%0d exp=0", diffs(), ok); end
    dt = (done_q.size() > 0) ? done_q[0] - vs_first + 1 : -1;
    checks++;
    if (dt != 120) begin failures++; $display("FAIL restart_done_clk got=%0d exp=120", dt); end
  endtask
  initial begin
    b0.en = 1'b0;
    b0.mode = 2'd0;
    b1.en = 1'b0;
    b1.mode = 2'd0;
    test_reset();
    test_mem_frame();
    test_random_mem();
    test_ramp();
    test_bars();
    test_en_drop();
    test_back_to_back();
    test_reset_mid_active();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
